ir_packet_scheduler: RTL and testbench
======================================

Name: ir_packet_scheduler

Overview:
Upstream companion of the IR transmitter state machine. It holds the car command written over the memory-mapped bus and generates the periodic one-cycle SEND_PACKET strobe. It also presents a COMMAND nibble that stays stable for the whole packet. It runs in the transmitter's clock domain and enforces packet spacing and a command watchdog.

Parameters:
BASE_ADDR, 8'h90, bus base address; +0 is the command register, +1 is the control register.
PACKET_PERIOD, 3600, cycles between periodic packets (10 Hz at 36 kHz).
MIN_SPACING, 600, minimum cycles between any two SEND_PACKET strobes; must be ≥ the maximum packet length (526 cycles for default transmitter timing).
WATCHDOG_PACKETS, 20, packets sent without a command write before COMMAND is forced to 0; 0 disables the watchdog.
TIMER_WIDTH, 12, width of the period timer; must hold PACKET_PERIOD-1.

Ports:
CLK  in  1  clock, shared with the transmitter.
RESET  in  1  reset; synchronous, active-high.
BUS_ADDR  in  8  bus address.
BUS_DATA  in  8  bus write data.
BUS_WE  in  1  bus write strobe, valid for one cycle.
SEND_PACKET  out  1  one-cycle packet start strobe, registered.
COMMAND  out  4  {forward, backward, left, right} bits [3:0], registered.
WD_EXPIRED  out  1  high while the watchdog has expired.

Behaviour:
- Reset: SEND_PACKET=0, COMMAND=0, WD_EXPIRED=0, cmd_reg=0, enable=0, send_pending=0, timer=0, wd_count=0, state=DISABLED. Reset mid-packet aborts the schedule with no further strobes.
- Write to BASE_ADDR+0: cmd_reg <= BUS_DATA[3:0] on the next edge; wd_count <= 0; WD_EXPIRED <= 0.
- Write to BASE_ADDR+1:
  - BUS_DATA[0] sets enable.
  - BUS_DATA[1]=1 sets send_pending. The bit is self-clearing and is not stored.
- Writes to other addresses are ignored. A write with BUS_WE low is ignored.
- States:
  - DISABLED: timer held at 0, no strobe. Goes to PULSE on the edge after enable becomes 1.
  - PULSE: lasts exactly one cycle.
    - SEND_PACKET=1.
    - COMMAND loads 0 if WD_EXPIRED, otherwise cmd_reg, on the same edge that raises SEND_PACKET.
    - timer <= 0, send_pending <= 0, wd_count increments and saturates.
    - Then goes to WAIT.
  - WAIT: timer increments each cycle.
    - Goes to PULSE when timer == PACKET_PERIOD-1, so the periodic strobe spacing is exactly PACKET_PERIOD cycles.
    - Also goes to PULSE when send_pending=1 and timer ≥ MIN_SPACING-1.
    - A pending request made before MIN_SPACING is held and fires when timer reaches MIN_SPACING-1.
    - If enable=0, goes to DISABLED and clears send_pending.
- Watchdog: when wd_count reaches WATCHDOG_PACKETS (nonzero), WD_EXPIRED goes high on that edge. Every later PULSE loads COMMAND=0.
- COMMAND changes only in PULSE and is otherwise held, including in DISABLED, so the transmitter sees a constant nibble across the packet.
- Simultaneous events:
  - A command write in the PULSE-entry cycle: the shadow captures the old cmd_reg; the new value applies from the next packet.
  - A write clearing enable while in PULSE: the strobe still completes; WAIT then exits to DISABLED on the next cycle.
  - Send-now while in DISABLED: ignored.
- Timer arithmetic is unsigned TIMER_WIDTH bits and never wraps, because it is reset at PACKET_PERIOD-1.

Decomposition:
- Shared package holds:
  - register offsets (CMD_OFS=0, CTRL_OFS=1);
  - state encoding (DISABLED, WAIT, PULSE);
  - command bit positions;
  - the MAX_PACKET_LEN constant derived from the transmitter burst/gap constants, used to check MIN_SPACING.
- One natural sub-module: ir_period_timer, a clear/enable/terminal-count counter with a ≥-threshold compare output.

Test Plan:
- Reset, then write ctrl=0x01 → SEND_PACKET pulses on the 2nd edge after the write, then again exactly 3600 cycles later, each pulse 1 cycle wide.
- Write cmd=0x5, then wait for a pulse → COMMAND=4'b0101 on the pulse edge and held unchanged for the following 3599 cycles.
- Write ctrl=0x03 at timer=100 → strobe occurs at timer=599 (600 cycles after the previous pulse). The same write at timer=1000 → strobe on the next cycle.
- No command writes for 20 packets with cmd=0xA → WD_EXPIRED rises at the 20th pulse and the 21st pulse carries COMMAND=0. A write of cmd=0x3 clears WD_EXPIRED, and the next pulse carries 0x3.
- Write ctrl=0x00 mid-WAIT → no further strobes and COMMAND is held. Re-enable → pulse after 2 edges. RESET asserted 50 cycles into WAIT → all outputs 0 and no strobe afterwards.
- A command write of 0xF in the same cycle the FSM enters PULSE → that pulse carries the old value and the next pulse carries 0xF.

Source files
------------

// File: rtl/ir_packet_scheduler_pkg.sv
// Shared constants for the IR packet scheduler: register map, FSM states, command layout.
// Transmitter timing constants live here so the scheduler can bound its minimum strobe spacing.
package ir_packet_scheduler_pkg;

    localparam logic [7:0] CMD_OFS  = 8'd0;
    localparam logic [7:0] CTRL_OFS = 8'd1;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_SEND_BIT   = 1;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_WAIT     = 2'd1,
        ST_PULSE    = 2'd2
    } sched_state_t;

    // Field order fixes the COMMAND bit positions: forward=3, backward=2, left=1, right=0.
    typedef struct packed {
        logic forward;
        logic backward;
        logic left;
        logic right;
    } cmd_t;

    localparam int TX_START_BURST = 88;
    localparam int TX_START_GAP   = 22;
    localparam int TX_ONE_BURST   = 30;
    localparam int TX_BIT_GAP     = 22;
    localparam int TX_NUM_BITS    = 8;

    // Worst case is an all-ones packet.
    localparam int MAX_PACKET_LEN = TX_START_BURST + TX_START_GAP
                                  + TX_NUM_BITS * (TX_ONE_BURST + TX_BIT_GAP);

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ir_packet_scheduler_timer.sv
// Packet period counter: synchronous clear, count enable, holds at terminal count.
// Flags are combinational from the count register; no backpressure.
module ir_period_timer #(
    parameter int WIDTH     = 12,
    parameter int TERMINAL  = 3599,
    parameter int THRESHOLD = 599
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic at_terminal,
    output logic at_threshold
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en && !at_terminal) begin
            count <= count + 1'b1;
        end
    end

    assign at_terminal  = (count == WIDTH'(TERMINAL));
    assign at_threshold = (count >= WIDTH'(THRESHOLD));

endmodule

// File: rtl/ir_packet_scheduler.sv
// Holds the bus-written car command and issues periodic/on-demand one-cycle SEND_PACKET strobes.
// Strobe and COMMAND are registered; send-now requests wait out the minimum spacing.
module ir_packet_scheduler
    import ir_packet_scheduler_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR        = 8'h90,
    parameter int         PACKET_PERIOD    = 3600,
    parameter int         MIN_SPACING      = 600,
    parameter int         WATCHDOG_PACKETS = 20,
    parameter int         TIMER_WIDTH      = 12
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic       SEND_PACKET,
    output logic [3:0] COMMAND,
    output logic       WD_EXPIRED
);

    // A send-now strobe must never cut into a packet still being transmitted.
    localparam int SPACING = max_int(MIN_SPACING, MAX_PACKET_LEN);
    localparam int WD_W    = $clog2(WATCHDOG_PACKETS + 2);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(WATCHDOG_PACKETS);

    sched_state_t    state;
    cmd_t            cmd_reg;
    logic            enable;
    logic            send_pending;
    logic [WD_W-1:0] wd_count;
    logic [WD_W-1:0] wd_inc;

    logic cmd_wr;
    logic ctrl_wr;
    logic go_pulse;
    logic timer_clr;
    logic at_terminal;
    logic at_threshold;
    logic unused_data;

    assign cmd_wr      = BUS_WE && (BUS_ADDR == 8'(BASE_ADDR + CMD_OFS));
    assign ctrl_wr     = BUS_WE && (BUS_ADDR == 8'(BASE_ADDR + CTRL_OFS));
    assign unused_data = ^BUS_DATA[7:4];
    assign wd_inc      = wd_count + 1'b1;

    always_comb begin
        go_pulse = 1'b0;
        case (state)
            ST_DISABLED: go_pulse = enable;
            ST_WAIT:     go_pulse = enable && (at_terminal || (send_pending && at_threshold));
            default:     go_pulse = 1'b0;
        endcase
    end

    assign timer_clr = (state == ST_DISABLED) || go_pulse;

    ir_period_timer #(
        .WIDTH     (TIMER_WIDTH),
        .TERMINAL  (PACKET_PERIOD - 1),
        .THRESHOLD (SPACING - 1)
    ) u_timer (
        .clk          (CLK),
        .reset        (RESET),
        .clr          (timer_clr),
        .en           (1'b1),
        .at_terminal  (at_terminal),
        .at_threshold (at_threshold)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_DISABLED;
            SEND_PACKET  <= 1'b0;
            COMMAND      <= 4'h0;
            WD_EXPIRED   <= 1'b0;
            cmd_reg      <= '0;
            enable       <= 1'b0;
            send_pending <= 1'b0;
            wd_count     <= '0;
        end else begin
            SEND_PACKET <= go_pulse;

            if (ctrl_wr) begin
                enable <= BUS_DATA[CTRL_ENABLE_BIT];
            end
            if (cmd_wr) begin
                cmd_reg <= cmd_t'(BUS_DATA[3:0]);
            end

            case (state)
                ST_DISABLED: if (go_pulse) state <= ST_PULSE;
                ST_PULSE:    state <= ST_WAIT;
                ST_WAIT: begin
                    if (!enable) begin
                        state <= ST_DISABLED;
                    end else if (go_pulse) begin
                        state <= ST_PULSE;
                    end
                end
                default:     state <= ST_DISABLED;
            endcase

            if ((state == ST_DISABLED) || ((state == ST_WAIT) && !enable)) begin
                send_pending <= 1'b0;
            end else if (ctrl_wr && BUS_DATA[CTRL_SEND_BIT]) begin
                send_pending <= 1'b1;
            end else if (go_pulse) begin
                send_pending <= 1'b0;
            end

            // The shadow samples cmd_reg before any same-cycle write lands.
            if (go_pulse) begin
                COMMAND <= WD_EXPIRED ? 4'h0 : 4'(cmd_reg);
                if ((WATCHDOG_PACKETS != 0) && (wd_count != WD_LIMIT)) begin
                    wd_count <= wd_inc;
                    if (wd_inc == WD_LIMIT) begin
                        WD_EXPIRED <= 1'b1;
                    end
                end
            end

            if (cmd_wr) begin
                wd_count   <= '0;
                WD_EXPIRED <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ir_packet_scheduler.sv
// Self-checking bench for ir_packet_scheduler against an event-time reference model.
module tb_ir_packet_scheduler;

    localparam int P  = 3600;
    localparam int MS = 600;
    localparam int WD = 4;
    localparam logic [7:0] CMD_A  = 8'h90;
    localparam logic [7:0] CTRL_A = 8'h91;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [7:0] BUS_ADDR = 8'h00;
    logic [7:0] BUS_DATA = 8'h00;
    logic       BUS_WE = 1'b0;
    logic       SEND_PACKET;
    logic [3:0] COMMAND;
    logic       WD_EXPIRED;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Reference model state: command register, packets since last command write, expiry flag.
    logic [3:0] m_cmd;
    int         m_since;
    bit         m_exp;
    int         last_t;
    logic [3:0] last_exp;

    ir_packet_scheduler #(
        .BASE_ADDR        (8'h90),
        .PACKET_PERIOD    (P),
        .MIN_SPACING      (MS),
        .WATCHDOG_PACKETS (WD),
        .TIMER_WIDTH      (12)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .BUS_ADDR    (BUS_ADDR),
        .BUS_DATA    (BUS_DATA),
        .BUS_WE      (BUS_WE),
        .SEND_PACKET (SEND_PACKET),
        .COMMAND     (COMMAND),
        .WD_EXPIRED  (WD_EXPIRED)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic model_reset();
        m_cmd = 4'h0; m_since = 0; m_exp = 1'b0;
    endtask

    task automatic model_cmd_write(input logic [3:0] d);
        m_cmd = d; m_since = 0; m_exp = 1'b0;
    endtask

    task automatic model_pulse(output logic [3:0] c);
        c = m_exp ? 4'h0 : m_cmd;
        if (WD != 0 && m_since < WD) begin
            m_since++;
            if (m_since == WD) m_exp = 1'b1;
        end
    endtask

    // Returns w = index of the edge that samples the write.
    task automatic bus_write(input logic [7:0] a, input logic [7:0] d, output int w);
        @(negedge CLK);
        BUS_ADDR = a; BUS_DATA = d; BUS_WE = 1'b1;
        w = cyc + 1;
        @(negedge CLK);
        BUS_WE = 1'b0;
    endtask

    task automatic wait_pulse(input int budget, output int t, output logic [3:0] e);
        bit found = 1'b0;
        t = -1; e = 4'h0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge CLK); #1;
            if (SEND_PACKET) begin
                found = 1'b1;
                t = cyc;
                model_pulse(e);
                last_t = t;
                last_exp = e;
            end
        end
    endtask

    task automatic test_reset();
        int n = 0;
        RESET = 1'b1;
        repeat (4) @(posedge CLK);
        @(negedge CLK); RESET = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        checks++; if (SEND_PACKET !== 1'b0) begin failures++; $display("FAIL reset_send: got %b expected 0", SEND_PACKET); end
        checks++; if (COMMAND !== 4'h0) begin failures++; $display("FAIL reset_command: got %h expected 0", COMMAND); end
        checks++; if (WD_EXPIRED !== 1'b0) begin failures++; $display("FAIL reset_wd: got %b expected 0", WD_EXPIRED); end
        repeat (30) begin @(posedge CLK); #1; if (SEND_PACKET) n++; end
        checks++; if (n !== 0) begin failures++; $display("FAIL disabled_quiet: got %0d strobes expected 0", n); end
    endtask

    task automatic test_enable_period();
        int w, t, t0; logic [3:0] e;
        bus_write(CTRL_A, 8'h01, w);
        wait_pulse(20, t, e);
        checks++; if (t !== w + 1) begin failures++; $display("FAIL enable_first_pulse: got edge %0d expected %0d", t, w + 1); end
        checks++; if (COMMAND !== e) begin failures++; $display("FAIL enable_first_cmd: got %h expected %h", COMMAND, e); end
        t0 = t;
        @(posedge CLK); #1;
        checks++; if (SEND_PACKET !== 1'b0) begin failures++; $display("FAIL pulse_width: got %b expected 0", SEND_PACKET); end
        wait_pulse(P + 20, t, e);
        checks++; if (t !== t0 + P) begin failures++; $display("FAIL period: got edge %0d expected %0d", t, t0 + P); end
    endtask

    task automatic test_command();
        int w, t, t0, n_p, n_c; logic [3:0] e; logic [3:0] val;
        for (int k = 0; k < 2; k++) begin
            val = (k == 0) ? 4'h5 : 4'($urandom_range(0, 15));
            bus_write(CMD_A, {4'h0, val}, w);
            model_cmd_write(val);
            bus_write(8'h92, 8'h0F, w);
            @(negedge CLK); BUS_ADDR = CMD_A; BUS_DATA = 8'h0F; BUS_WE = 1'b0;
            t0 = last_t;
            wait_pulse(P + 20, t, e);
            checks++; if (t !== t0 + P) begin failures++; $display("FAIL cmd_pulse_time: got edge %0d expected %0d", t, t0 + P); end
            checks++; if (COMMAND !== e) begin failures++; $display("FAIL cmd_value: got %h expected %h", COMMAND, e); end
            n_p = 0; n_c = 0;
            for (int i = 1; i < P; i++) begin
                @(posedge CLK); #1;
                if (SEND_PACKET) n_p++;
                if (COMMAND !== e) n_c++;
            end
            checks++; if (n_p !== 0) begin failures++; $display("FAIL cmd_hold_strobes: got %0d expected 0", n_p); end
            checks++; if (n_c !== 0) begin failures++; $display("FAIL cmd_hold_changes: got %0d expected 0", n_c); end
            t0 = last_t;
            wait_pulse(P + 20, t, e);
            checks++; if (t !== t0 + P) begin failures++; $display("FAIL cmd_next_time: got edge %0d expected %0d", t, t0 + P); end
        end
    endtask

    task automatic test_send_now();
        int w, t, t0, exp_t; logic [3:0] e;
        int offs[3];
        offs[0] = 100; offs[1] = 1000; offs[2] = int'($urandom_range(1, 3300));
        for (int k = 0; k < 3; k++) begin
            t0 = last_t;
            repeat (offs[k]) @(posedge CLK);
            bus_write(CTRL_A, 8'h03, w);
            exp_t = (w + 1 > t0 + MS) ? w + 1 : t0 + MS;
            wait_pulse(P + 20, t, e);
            checks++; if (t !== exp_t) begin failures++; $display("FAIL send_now_time[%0d]: got edge %0d expected %0d", offs[k], t, exp_t); end
            checks++; if (COMMAND !== e) begin failures++; $display("FAIL send_now_cmd: got %h expected %h", COMMAND, e); end
        end
    endtask

    task automatic test_watchdog();
        int w, t, t0, exp_t; logic [3:0] e;
        bus_write(CMD_A, 8'h0A, w);
        model_cmd_write(4'hA);
        for (int k = 0; k <= WD; k++) begin
            t0 = last_t;
            bus_write(CTRL_A, 8'h03, w);
            exp_t = (w + 1 > t0 + MS) ? w + 1 : t0 + MS;
            wait_pulse(P + 20, t, e);
            checks++; if (t !== exp_t) begin failures++; $display("FAIL wd_pulse_time: got edge %0d expected %0d", t, exp_t); end
            checks++; if (COMMAND !== e) begin failures++; $display("FAIL wd_cmd[%0d]: got %h expected %h", k, COMMAND, e); end
            checks++; if (WD_EXPIRED !== m_exp) begin failures++; $display("FAIL wd_flag[%0d]: got %b expected %b", k, WD_EXPIRED, m_exp); end
        end
        bus_write(CMD_A, 8'h03, w);
        model_cmd_write(4'h3);
        checks++; if (WD_EXPIRED !== 1'b0) begin failures++; $display("FAIL wd_clear: got %b expected 0", WD_EXPIRED); end
        bus_write(CTRL_A, 8'h03, w);
        wait_pulse(P + 20, t, e);
        checks++; if (COMMAND !== e) begin failures++; $display("FAIL wd_recover_cmd: got %h expected %h", COMMAND, e); end
    endtask

    task automatic test_disable_reset();
        int w, t, n_p, n_c; logic [3:0] e; logic [3:0] held;
        held = last_exp;
        repeat (200) @(posedge CLK);
        bus_write(CTRL_A, 8'h00, w);
        n_p = 0; n_c = 0;
        repeat (P + 100) begin
            @(posedge CLK); #1;
            if (SEND_PACKET) n_p++;
            if (COMMAND !== held) n_c++;
        end
        checks++; if (n_p !== 0) begin failures++; $display("FAIL disable_strobes: got %0d expected 0", n_p); end
        checks++; if (n_c !== 0) begin failures++; $display("FAIL disable_cmd_held: got %0d changes expected 0", n_c); end
        bus_write(CTRL_A, 8'h01, w);
        wait_pulse(20, t, e);
        checks++; if (t !== w + 1) begin failures++; $display("FAIL reenable_time: got edge %0d expected %0d", t, w + 1); end
        checks++; if (COMMAND !== e) begin failures++; $display("FAIL reenable_cmd: got %h expected %h", COMMAND, e); end
        repeat (50) @(posedge CLK);
        @(negedge CLK); RESET = 1'b1;
        @(negedge CLK); RESET = 1'b0;
        model_reset();
        checks++; if ({SEND_PACKET, COMMAND, WD_EXPIRED} !== 6'b0) begin failures++; $display("FAIL midreset_outputs: got %b expected 000000", {SEND_PACKET, COMMAND, WD_EXPIRED}); end
        n_p = 0;
        repeat (P + 400) begin @(posedge CLK); #1; if (SEND_PACKET) n_p++; end
        checks++; if (n_p !== 0) begin failures++; $display("FAIL midreset_quiet: got %0d strobes expected 0", n_p); end
    endtask

    task automatic test_collision();
        int w, t, t0; logic [3:0] e; logic [3:0] old;
        bus_write(CTRL_A, 8'h01, w);
        wait_pulse(20, t, e);
        checks++; if (t !== w + 1) begin failures++; $display("FAIL coll_enable_time: got edge %0d expected %0d", t, w + 1); end
        old = 4'($urandom_range(0, 14));
        bus_write(CMD_A, {4'h0, old}, w);
        model_cmd_write(old);
        t0 = last_t;
        wait_pulse(P + 20, t, e);
        checks++; if (t !== t0 + P) begin failures++; $display("FAIL coll_pre_time: got edge %0d expected %0d", t, t0 + P); end
        checks++; if (COMMAND !== e) begin failures++; $display("FAIL coll_pre_cmd: got %h expected %h", COMMAND, e); end
        t0 = last_t;
        repeat (P - 1) @(posedge CLK);
        bus_write(CMD_A, 8'h0F, w);
        model_pulse(e);
        last_t = t0 + P;
        model_cmd_write(4'hF);
        checks++; if (SEND_PACKET !== 1'b1) begin failures++; $display("FAIL coll_strobe: got %b expected 1", SEND_PACKET); end
        checks++; if (COMMAND !== e) begin failures++; $display("FAIL coll_old_cmd: got %h expected %h", COMMAND, e); end
        t0 = last_t;
        wait_pulse(P + 20, t, e);
        checks++; if (t !== t0 + P) begin failures++; $display("FAIL coll_next_time: got edge %0d expected %0d", t, t0 + P); end
        checks++; if (COMMAND !== e) begin failures++; $display("FAIL coll_new_cmd: got %h expected %h", COMMAND, e); end
    endtask

    initial begin
        model_reset();
        last_t = 0;
        last_exp = 4'h0;
        test_reset();
        test_enable_period();
        test_command();
        test_send_now();
        test_watchdog();
        test_disable_reset();
        test_collision();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
